countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter: the decrementing counterpart to the team's 4-bit up-counter (counter2).
- Software or upstream logic loads a start value. The block counts toward zero at a prescaled rate while enabled.
- Pulses a terminal-count flag on expiry. Optionally auto-reloads for periodic ticks.
- Sits beside counter2 in the FPGA examples. Drives LED blink timing and timeout events.

Parameters:
- WIDTH, 4, bit width of count_out and load_value.
- PRESCALE, 1, enabled clk cycles per decrement; must be >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- enable  input  1  count permission; low pauses counting (value and prescaler hold).
- load  input  1  one-cycle load strobe.
- load_value  input  WIDTH  start/reload value, sampled when load=1.
- auto_reload  input  1  1 = reload from stored value on expiry; 0 = stop at zero.
- count_out  output  WIDTH  current count (registered).
- tc  output  1  terminal count; registered, one-cycle pulse.
- busy  output  1  1 while in RUN state.

Behaviour:
- Reset (reset=0, asynchronous):
  - count_out=0, tc=0, busy=0.
  - Prescaler=0, reload register=0, state=IDLE.
  - Takes effect mid-run with no completion pulse.
- States: IDLE, RUN. busy = (state==RUN), registered.
- tick: enable=1 and prescaler==PRESCALE-1.
  - On tick, the prescaler returns to 0; otherwise, when enable=1, it increments.
  - With enable=0 the prescaler holds.
  - With PRESCALE=1 every enabled cycle is a tick.
- load=1 has the highest priority after reset, in any state:
  - count_out<=load_value, reload register<=load_value, prescaler<=0, tc<=0.
  - state<=RUN if load_value!=0, else IDLE.
  - Load coinciding with a tick: load wins, no decrement, no tc.
- RUN, tick, count_out>1: count_out<=count_out-1.
- RUN, tick, count_out==1: tc<=1 for exactly that next cycle.
  - auto_reload=1: count_out<=reload register, remain RUN; 0 is never shown.
  - auto_reload=0: count_out<=0, state<=IDLE; busy falls on the same edge tc rises.
- RUN, enable=0: all state holds; busy stays 1; no tc.
- IDLE: enable and ticks are ignored; count_out holds (0 after expiry). Only load leaves IDLE.
- tc is 0 on every cycle not described above. It is never high for two consecutive cycles unless reload value==1 with auto_reload=1 and PRESCALE=1, in which case tc stays high every cycle.
- auto_reload is sampled at the expiry tick only; changing it mid-count is legal.
- Arithmetic: unsigned WIDTH-bit. Decrement never underflows because expiry is detected at 1. Max load 2^WIDTH-1.
- Latency: load to count_out visible is 1 clk. Expiry with PRESCALE=1: load value N gives tc high N clk after count_out first shows N.

Decomposition:
- Shared package/include (timer_defs):
  - State encoding constants: IDLE=1'b0, RUN=1'b1.
  - Default WIDTH/PRESCALE constants.
- One sub-module: tick_gen.
  - Parameter PRESCALE; inputs clk, reset, enable, clear; output tick.
  - Holds a $clog2(PRESCALE)+1-bit prescaler.
  - clear is driven by load.
- countdown_timer contains the FSM, count register and reload register.

Test Plan:
- Basic expiry (WIDTH=4, PRESCALE=1, auto_reload=0): release reset, load 5 with enable=1 -> count_out 5,4,3,2,1,0 on successive cycles; tc=1 only in the cycle count_out becomes 0; busy 1→0 on that edge; count_out stays 0.
- Pause: load 6, enable high 2 cycles, then low 4 cycles, then high -> count_out 6,5,4, holds 4 for 4 cycles with busy=1 and tc=0, then resumes 3,2,1,0.
- Auto-reload (load 3, auto_reload=1): count_out 3,2,1,3,2,1,3… -> tc pulses every 3rd cycle; busy stays 1; 0 never appears.
- Prescaler (PRESCALE=3, load 2, enable=1) -> count_out holds 3 cycles per value: 2,2,2,1,1,1,0; tc exactly once.
- Collisions:
  - Load 9 on the same cycle count_out would go 1→0 -> count_out=9, tc=0, busy=1.
  - Load 0 -> count_out=0, busy=0, no tc.
- Async reset mid-run (count_out=7): drive reset low between clk edges -> count_out=0, busy=0, tc=0 immediately. After release, outputs stay in IDLE until the next load.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and
// default sizing used when the timer is instantiated without overrides.
package timer_defs;

    // IDLE: count held, waiting for a load. RUN: counting toward expiry.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_PRESCALE = 1;

    // Number of bits needed to hold prescaler values 0..prescale-1, with
    // one spare bit so a prescale of 1 still gets a legal 1-bit vector.
    function automatic int prescaler_bits(input int prescale);
        return $clog2(prescale) + 1;
    endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler for the countdown timer. Emits a single-cycle tick once every
// PRESCALE enabled clock cycles. The prescaler pauses while enable is low
// and restarts from zero when clear is asserted.
module tick_gen
    import timer_defs::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            PW   = prescaler_bits(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler;

    // A tick fires on the last enabled cycle of each prescale period; with
    // PRESCALE=1 LAST is zero, so every enabled cycle is a tick.
    assign tick = enable && (prescaler == LAST);

    // Prescaler: cleared by reset or clear, wraps on tick, holds when disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (clear) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else if (enable) begin
            prescaler <= prescaler + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled decrement, a one-cycle terminal-count
// pulse on expiry and optional automatic reload for periodic ticks.
// busy mirrors the FSM state register directly (1 = RUN), so the state is
// always visible at the boundary.
module countdown_timer
    import timer_defs::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] reload_value;
    logic             tick;

    // The prescaler restarts on every load so the first decrement after a
    // load always comes a full prescale period later.
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (load),
        .tick   (tick)
    );

    // busy is the state flop itself, so it is registered with no extra stage.
    assign busy = (state == RUN);

    // FSM, count register and reload register. Load outranks everything but
    // reset; expiry is detected at 1 so the count never wraps below zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count_out    <= '0;
            reload_value <= '0;
            tc           <= 1'b0;
        end else if (load) begin
            count_out    <= load_value;
            reload_value <= load_value;
            tc           <= 1'b0;
            state        <= (load_value != '0) ? RUN : IDLE;
        end else begin
            tc <= 1'b0;
            case (state)
                RUN: begin
                    if (tick) begin
                        if (count_out > WIDTH'(1)) begin
                            count_out <= count_out - WIDTH'(1);
                        end else begin
                            // Expiry: auto_reload is only looked at here.
                            tc <= 1'b1;
                            if (auto_reload) begin
                                count_out <= reload_value;
                            end else begin
                                count_out <= '0;
                                state     <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE ignores enable and ticks; only a load leaves it.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer. Two instances share all inputs: dut1 uses
// PRESCALE=1, dut3 uses PRESCALE=3. Each scenario task pushes the expected
// {count_out, tc, busy} for a cycle as it drives that cycle's stimulus, then
// pops and compares once the DUT has clocked.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clk         = 1'b0;
    logic         reset       = 1'b1;
    logic         enable      = 1'b0;
    logic         load        = 1'b0;
    logic [W-1:0] load_value  = '0;
    logic         auto_reload = 1'b0;

    logic [W-1:0] count1, count3;
    logic         tc1, tc3, busy1, busy3;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [5:0]   exp_q[$];

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .count_out   (count1),
        .tc          (tc1),
        .busy        (busy1)
    );

    countdown_timer #(.WIDTH(W), .PRESCALE(3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .count_out   (count3),
        .tc          (tc3),
        .busy        (busy3)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Packs an expected {count, tc, busy} triple.
    function automatic logic [5:0] pk(input int c, input int t, input int b);
        logic [5:0] r;
        r = {c[3:0], t[0], b[0]};
        return r;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: apply one cycle's inputs.
    task automatic drive(input logic ld, input logic [W-1:0] lv,
                         input logic en, input logic ar);
        load        = ld;
        load_value  = lv;
        enable      = en;
        auto_reload = ar;
    endtask

    task automatic test_reset();
        logic [5:0] got, exp;
        #1 reset = 1'b0;
        #10;
        exp_q.push_back(pk(0, 0, 0));
        got = {count1, tc1, busy1};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_p1: got %h expected %h", got, exp);
        end
        exp_q.push_back(pk(0, 0, 0));
        got = {count3, tc3, busy3};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_p3: got %h expected %h", got, exp);
        end
        step();
        reset = 1'b1;
        // After release, enable alone must not start anything.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 1'b1, 1'b0);
            exp_q.push_back(pk(0, 0, 0));
            step();
            got = {count1, tc1, busy1};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_basic();
        logic [5:0] got, exp;
        logic [5:0] tbl[8];
        tbl = '{pk(5,0,1), pk(4,0,1), pk(3,0,1), pk(2,0,1),
                pk(1,0,1), pk(0,1,0), pk(0,0,0), pk(0,0,0)};
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 4'd5, 1'b1, 1'b0);
            exp_q.push_back(tbl[i]);
            step();
            got = {count1, tc1, busy1};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL basic cycle %0d: got count=%0d tc=%b busy=%b expected count=%0d tc=%b busy=%b",
                         i, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_pause();
        logic [5:0] got, exp;
        logic [5:0] tbl[11];
        int         en_tbl[11] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        tbl = '{pk(6,0,1), pk(5,0,1), pk(4,0,1), pk(4,0,1), pk(4,0,1), pk(4,0,1),
                pk(4,0,1), pk(3,0,1), pk(2,0,1), pk(1,0,1), pk(0,1,0)};
        for (int i = 0; i < 11; i++) begin
            drive(i == 0, 4'd6, en_tbl[i] != 0, 1'b0);
            exp_q.push_back(tbl[i]);
            step();
            got = {count1, tc1, busy1};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL pause cycle %0d: got count=%0d tc=%b busy=%b expected count=%0d tc=%b busy=%b",
                         i, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_auto_reload();
        logic [5:0] got, exp;
        logic [5:0] tbl[10];
        logic [5:0] tbl1[6];
        // Reload 3, auto_reload dropped just before the third expiry.
        tbl = '{pk(3,0,1), pk(2,0,1), pk(1,0,1), pk(3,1,1), pk(2,0,1),
                pk(1,0,1), pk(3,1,1), pk(2,0,1), pk(1,0,1), pk(0,1,0)};
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, 4'd3, 1'b1, i < 9);
            exp_q.push_back(tbl[i]);
            step();
            got = {count1, tc1, busy1};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL auto_reload cycle %0d: got count=%0d tc=%b busy=%b expected count=%0d tc=%b busy=%b",
                         i, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
            end
        end
        // Reload value 1: tc is held high every cycle until auto_reload drops.
        tbl1 = '{pk(1,0,1), pk(1,1,1), pk(1,1,1), pk(1,1,1), pk(0,1,0), pk(0,0,0)};
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, 4'd1, 1'b1, i < 4);
            exp_q.push_back(tbl1[i]);
            step();
            got = {count1, tc1, busy1};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reload_one cycle %0d: got count=%0d tc=%b busy=%b expected count=%0d tc=%b busy=%b",
                         i, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_prescale();
        logic [5:0] got, exp;
        logic [5:0] tbl[10];
        tbl = '{pk(2,0,1), pk(2,0,1), pk(2,0,1), pk(1,0,1), pk(1,0,1),
                pk(1,0,1), pk(0,1,0), pk(0,0,0), pk(0,0,0), pk(0,0,0)};
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, 4'd2, 1'b1, 1'b0);
            exp_q.push_back(tbl[i]);
            step();
            got = {count3, tc3, busy3};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL prescale cycle %0d: got count=%0d tc=%b busy=%b expected count=%0d tc=%b busy=%b",
                         i, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_collision();
        logic [5:0] got, exp;
        logic [5:0] tbl[8];
        int         ld_tbl[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int         lv_tbl[8] = '{2, 0, 9, 0, 0, 0, 15, 0};
        // Load 9 lands on the 1->0 tick; load 0 goes idle; load 15 is max.
        tbl = '{pk(2,0,1), pk(1,0,1), pk(9,0,1), pk(8,0,1),
                pk(0,0,0), pk(0,0,0), pk(15,0,1), pk(14,0,1)};
        for (int i = 0; i < 8; i++) begin
            drive(ld_tbl[i] != 0, 4'(lv_tbl[i]), 1'b1, 1'b0);
            exp_q.push_back(tbl[i]);
            step();
            got = {count1, tc1, busy1};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL collision cycle %0d: got count=%0d tc=%b busy=%b expected count=%0d tc=%b busy=%b",
                         i, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] got, exp;
        logic [5:0] tbl[3];
        tbl = '{pk(9,0,1), pk(8,0,1), pk(7,0,1)};
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, 4'd9, 1'b1, 1'b0);
            exp_q.push_back(tbl[i]);
            step();
            got = {count1, tc1, busy1};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL async_pre cycle %0d: got %h expected %h", i, got, exp);
            end
        end
        // Assert reset between edges; outputs must clear without a clock.
        #3 reset = 1'b0;
        exp_q.push_back(pk(0, 0, 0));
        #1;
        got = {count1, tc1, busy1};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL async_p1: got %h expected %h", got, exp);
        end
        exp_q.push_back(pk(0, 0, 0));
        got = {count3, tc3, busy3};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL async_p3: got %h expected %h", got, exp);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 1'b1, 1'b1);
            exp_q.push_back(pk(0, 0, 0));
            step();
            got = {count1, tc1, busy1};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL async_post cycle %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_auto_reload();
        test_prescale();
        test_collision();
        test_async_reset();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
